rom_fetch: RTL

- Sequential fetch engine directly upstream of the synchronous simulation ROM.
- Drives the ROM address and captures the registered read data one cycle later.
- Buffers returned words in a small FIFO and presents them, tagged with their address, to a downstream consumer over a valid/ready handshake.
- Supports start/redirect and halt with clean flush of in-flight reads; used as the instruction/data streamer in the mig DV environment.

---
 rtl/rom_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rom_fetch.sv
// Sequential fetch engine feeding a synchronous ROM: issues addresses, captures read data
// one cycle later and streams {data, address} through a small FIFO. Trace: ROM_FETCH_TRACE_EN.
module rom_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           start_addr,
  input  logic                            halt,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  input  logic [DATA_SIZE*DATA_WIDTH-1:0] rom_data,
  output logic                            out_valid,
  output logic [DATA_SIZE*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]           out_addr,
  input  logic                            out_ready,
  output logic                            busy
);

  localparam int WORD_W = DATA_SIZE * DATA_WIDTH;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [ADDR_WIDTH-1:0]   iss_addr_r;
  logic                    inflight_r;
  logic [WORD_W-1:0]       mem_data_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   mem_addr_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    issue_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    credit_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign out_data  = out_valid ? mem_data_r[rd_ptr_r] : {WORD_W{1'b0}};
  assign out_addr  = out_valid ? mem_addr_r[rd_ptr_r] : {ADDR_WIDTH{1'b0}};
  assign rom_addr  = pc_r;
  assign busy      = (state_r != IDLE);
  assign pop_s     = out_valid & out_ready;
  // A start flushes the FIFO, so a word returning in that same cycle is dropped.
  assign push_s    = inflight_r & ~start;
  assign credit_ok_s = (count_r + CNT_W'(inflight_r)) < (CNT_W'(FIFO_DEPTH) + CNT_W'(pop_s));

  // Next-state and issue decision
  always_comb begin
    state_nx_s = state_r;
    issue_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = RUN;
        else       state_nx_s = IDLE;
      end
      RUN: begin
        issue_s = ~start & credit_ok_s;
        if (start)     state_nx_s = RUN;
        else if (halt) state_nx_s = DRAIN;
        else           state_nx_s = RUN;
      end
      DRAIN: begin
        if (start)                                                state_nx_s = RUN;
        else if (!inflight_r && count_r == {CNT_W{1'b0}})          state_nx_s = IDLE;
        else                                                      state_nx_s = DRAIN;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, program counter and in-flight read tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pc_r       <= {ADDR_WIDTH{1'b0}};
      iss_addr_r <= {ADDR_WIDTH{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      inflight_r <= issue_s;
      if (start) begin
        pc_r <= start_addr;
      end else if (issue_s) begin
        pc_r       <= pc_r + ADDR_WIDTH'(DATA_SIZE);
        iss_addr_r <= pc_r;
      end
    end
  end

  // Output FIFO: capture returning words, release on handshake, flush on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_r[i] <= {WORD_W{1'b0}};
        mem_addr_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (start) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= rom_data;
        mem_addr_r[wr_ptr_r] <= iss_addr_r;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

`ifdef ROM_FETCH_TRACE_EN
  // Simulation trace of accepted words, starts and returns to idle
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (pop_s) $display("FETCH[%h]=%h", out_addr, out_data);
      if (start) $display("rom_fetch start addr=%h", start_addr);
      if (state_r != IDLE && state_nx_s == IDLE) $display("rom_fetch idle");
    end
  end
`else
`endif

endmodule
